// File: rtl/rr_arbiter10_pkg.sv
// ----------------------------------------------------------------------------
// rr_arbiter10_pkg
// Shared definitions for the 10-way round-robin arbiter:
//   - NUM_REQ   : number of requesters sharing the resource
//   - IDX_W     : width of a requester index
//   - PTR_RESET : "last grantee" after reset, chosen so that the first search
//                 after reset starts at requester 0
//   - state_t   : arbiter FSM encoding (IDLE / GRANT / GAP)
// ----------------------------------------------------------------------------
package rr_arbiter10_pkg;

  localparam int NUM_REQ = 10;
  localparam int IDX_W   = 4;

  localparam logic [IDX_W-1:0] PTR_RESET = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter10_decoder.sv
// ----------------------------------------------------------------------------
// decoder4to10_jdl25175
// 4-to-10 one-hot decoder with enable.
// Ports:
//   enable  in   1   when low the output is all zeros
//   dec_in  in   4   binary index, 0..9 are decoded
//   dec_out out  10  one-hot image of dec_in (all zeros for 10..15)
// ----------------------------------------------------------------------------
module decoder4to10_jdl25175 (
  input  logic       enable,
  input  logic [3:0] dec_in,
  output logic [9:0] dec_out
);

  // Codes 10..15 have no requester behind them, so they decode to nothing;
  // this keeps the output at most one-hot for every possible input.
  always_comb begin
    dec_out = '0;
    if (enable && (dec_in < 4'd10)) begin
      dec_out = 10'd1 << dec_in;
    end
  end

endmodule

// File: rtl/rr_arbiter10.sv
// ----------------------------------------------------------------------------
// rr_arbiter10
// Round-robin arbiter sharing one resource among 10 requesters, with a
// hold-time limit so no single requester can starve the others.
// Parameters:
//   MAX_HOLD  maximum consecutive cycles a grant may be held (1..31)
//   HOLD_W    width of the hold counter, 2^HOLD_W > MAX_HOLD
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   req        in   10  request lines, bit i = requester i wants the resource
//   done       in   1   current grantee releases the resource (GRANT only)
//   gnt_idx    out  4   index of current / most recent grantee (registered)
//   gnt_valid  out  1   high while a grant is active
//   gnt        out  10  one-hot grant, decode(gnt_idx) gated by gnt_valid
//   timeout    out  1   one-cycle pulse when a grant is revoked at MAX_HOLD
// ----------------------------------------------------------------------------
module rr_arbiter10
  import rr_arbiter10_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic [NUM_REQ-1:0] gnt,
  output logic               timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [HOLD_W-1:0]  hold_cnt;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               cur_req;
  logic               release_now;

  // Round-robin search: scan from (last + 1) upward, wrapping 9 -> 0, so the
  // last grantee is examined last and only wins when nobody else asks.
  // Result is {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   last);
    logic             found;
    logic [IDX_W-1:0] win;
    int               cand;
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!found && r[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
    return {found, win};
  endfunction

  // Winner of the search, relevant only in IDLE and GAP.
  always_comb begin
    {pick_found, pick_idx} = rr_pick(req, ptr);
  end

  // Grant release: the grantee is done, has dropped its request, or has used
  // up its hold budget on this edge.
  always_comb begin
    cur_req     = (gnt_idx < 4'(NUM_REQ)) ? req[gnt_idx] : 1'b0;
    release_now = done || !cur_req || (hold_cnt == HOLD_LAST);
  end

  // Arbiter FSM. GAP always lasts one cycle, giving a dead cycle between
  // back-to-back grants. timeout is a single-cycle pulse, so it defaults low
  // every edge and is only raised when the hold limit alone ended the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= PTR_RESET;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (pick_found) begin
            state     <= GRANT;
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (release_now) begin
            state     <= GAP;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx;
            timeout   <= !done && cur_req;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  // One-hot grant vector derived from the registered index.
  decoder4to10_jdl25175 u_dec (
    .enable  (gnt_valid),
    .dec_in  (gnt_idx),
    .dec_out (gnt)
  );

endmodule

// File: doc/rr_arbiter10.md
Name: rr_arbiter10

Overview:
- Round-robin arbiter that shares one resource among up to 10 requesters.
- Each cycle, at most one requester holds the resource.
- Outputs the 4-bit grant index plus a one-hot 10-bit grant vector. The one-hot vector is produced by feeding the index through a 4-to-10 decoder.
- Sits between the requester blocks and the shared resource. A hold-time limit stops any single requester from starving the others.

Parameters:
- MAX_HOLD, default 16: maximum consecutive cycles one grant may be held (legal range 1..31).
- HOLD_W, default 5: width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  10  request lines; bit i high means requester i wants the resource.
- done  input  1  current grantee releases the resource; sampled only in GRANT.
- gnt_idx  output  4  index of the current grantee, 0..9; registered.
- gnt_valid  output  1  high while a grant is active.
- gnt  output  10  one-hot grant, equal to decode(gnt_idx) when gnt_valid=1, else all zeros.
- timeout  output  1  one-cycle pulse when a grant is revoked because it hit MAX_HOLD.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, ptr=9, gnt_idx=0, gnt_valid=0, gnt=0, timeout=0, hold_cnt=0.
- States: IDLE, GRANT, GAP. ptr holds the index of the last grantee.
- Arbitration (in IDLE and GAP):
  - Search req starting at (ptr+1) mod 10 and wrap 9->0.
  - The first set bit wins. Bits 10..15 do not exist, so gnt_idx is never greater than 9.
  - If a winner exists: next state GRANT, gnt_idx=winner, gnt_valid=1, hold_cnt=0.
  - Otherwise IDLE is held, or GAP goes to IDLE.
- Latency: a request seen in IDLE at edge t gives gnt_valid=1 after edge t, i.e. a one-cycle registered response.
- GRANT, stay (hold_cnt increments) while all of these hold:
  - req[gnt_idx]=1,
  - done=0,
  - hold_cnt < MAX_HOLD-1.
- GRANT, release on the first edge where any of these is true:
  - done=1,
  - req[gnt_idx]=0,
  - hold_cnt == MAX_HOLD-1.
- On release:
  - next state GAP, gnt_valid=0, gnt=0, ptr=gnt_idx.
  - gnt_idx retains its value.
  - timeout=1 only when release was caused solely by hold_cnt == MAX_HOLD-1 (done=0 and req still high).
- GAP:
  - lasts exactly one cycle and clears timeout.
  - arbitrates as above, so back-to-back grants are separated by exactly one idle cycle.
  - The just-released requester has lowest priority. If it is the only requester, it is re-granted.
- Grant length: at most MAX_HOLD cycles.
  - With MAX_HOLD=1 every grant lasts one cycle.
  - Release is then always by timeout unless done or request-drop occurs on that same edge; in that case timeout=0.
- Simultaneous events:
  - done=1 together with hold_cnt == MAX_HOLD-1 gives a normal release, timeout=0.
  - New requests arriving during GRANT are ignored until GAP.
- Reset mid-grant: outputs drop immediately (asynchronously) to their reset values. After rst_n rises, arbitration restarts from index 0.
- gnt is a combinational decode of the registered gnt_idx, gated by gnt_valid. It must never show more than one bit set.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, GRANT=2'd1, GAP=2'd2) and the constant NUM_REQ=10.
- Round-robin search is a combinational function inside rr_arbiter10.
- One sub-module instance is natural: decoder4to10_jdl25175, with enable tied to gnt_valid and dec_in tied to gnt_idx, driving gnt.

Test Plan:
- Reset then req=10'b0000001000 -> edge after request: gnt_idx=3, gnt_valid=1, gnt=10'b0000001000. Assert done for 1 cycle -> next edge gnt_valid=0; next edge gnt_idx=3 again.
- req=10'b1000100100 held, done pulsed each grant -> grant order 2, 5, 9, 2 with exactly one gnt_valid=0 cycle between grants.
- Wrap: ptr=9 after granting 9, req=10'b1000000001 -> next grant is 0, not 9.
- Timeout: MAX_HOLD=16, req[7] held high, done=0 -> gnt_valid high for exactly 16 cycles, then timeout=1 for 1 cycle in GAP, then gnt_idx=7 re-granted.
- done=1 on the same edge hold_cnt reaches 15 -> release with timeout=0. Separately, drop req[4] mid-grant -> release on the next edge.
- rst_n low for 1 ns in the middle of a grant on index 6 -> gnt_valid=0 and gnt=0 immediately. After release with req=10'b1111111111, the first grant is index 0.
